// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hazard_ctrl
// Brief    : Pipeline enable/flush control, run/wait/halt FSM and perf counters
//            for the 5-stage MIPS core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             idex_DRen,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             pc_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             halt_q;
    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

    logic w_dbusy;
    logic w_lu;
    logic w_active;
    logic w_redirect;

    assign w_dbusy  = (mem_dREN | mem_dWEN) & ~dhit;
    assign w_lu     = idex_DRen & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign w_active = (state_q != S_HALT);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        w_redirect  = 1'b0;
        state_d     = state_q;

        if (w_active) begin
            state_d = S_RUN;
            if (wb_halt) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_d     = S_HALT;
            end else if (w_dbusy) begin
                memwb_flush = 1'b1;
                state_d     = S_MEMWAIT;
            end else if (!ihit) begin
                // Front end frozen; the MEM-stage bubble lets the back end drain.
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end else if (pc_redirect) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                w_redirect = 1'b1;
            end else if (w_lu) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_RUN;
            halt_q  <= 1'b0;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == S_HALT);
            if (w_active) begin
                cycle_q <= cycle_q + C_ONE;
                if (!pc_en)
                    stall_q <= stall_q + C_ONE;
                if (w_redirect)
                    flush_q <= flush_q + C_ONE;
            end
        end
    end

    assign halt      = halt_q;
    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, idex_DRen, pc_redirect, wb_halt;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_halted;
    bit [31:0]   m_cycle, m_stall, m_flush;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .idex_DRen(idex_DRen),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .pc_redirect(pc_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,memwb}_en followed by {ifid,idex,exmem,memwb}_flush.
    function automatic logic [8:0] ref_ctrl(input bit halted);
        bit dbusy = (mem_dREN || mem_dWEN) && !dhit;
        bit lu = idex_DRen && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (halted)      return 9'b00000_0000;
        if (wb_halt)     return 9'b00000_1110;
        if (dbusy)       return 9'b00000_0001;
        if (!ihit)       return 9'b00001_0010;
        if (pc_redirect) return 9'b11111_1100;
        if (lu)          return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    function automatic bit ref_is_redirect();
        bit dbusy = (mem_dREN || mem_dWEN) && !dhit;
        return !m_halted && !wb_halt && !dbusy && ihit && pc_redirect;
    endfunction

    task automatic check_all(input string tag);
        logic [8:0] obs;
        obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush};
        check_eq({tag, ".ctrl"},  {55'd0, obs}, {55'd0, ref_ctrl(m_halted)});
        check_eq({tag, ".halt"},  {63'd0, halt}, {63'd0, m_halted});
        check_eq({tag, ".cycle"}, {32'd0, cycle_cnt}, {32'd0, m_cycle});
        check_eq({tag, ".stall"}, {32'd0, stall_cnt}, {32'd0, m_stall});
        check_eq({tag, ".flush"}, {32'd0, flush_cnt}, {32'd0, m_flush});
    endtask

    // Inputs are set at posedge+1; check mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        logic [8:0] exp;
        bit         redir;
        #3;
        check_all(tag);
        exp   = ref_ctrl(m_halted);
        redir = ref_is_redirect();
        @(posedge CLK);
        if (!m_halted) begin
            m_cycle = m_cycle + 1;
            if (!exp[8]) m_stall = m_stall + 1;
            if (redir)   m_flush = m_flush + 1;
            if (wb_halt) m_halted = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        idex_DRen = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        pc_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic rand_inputs();
        ihit        = ($urandom_range(0, 3) != 0);
        dhit        = $urandom_range(0, 1) == 1;
        mem_dREN    = ($urandom_range(0, 3) == 0);
        mem_dWEN    = !mem_dREN && ($urandom_range(0, 5) == 0);
        idex_DRen   = $urandom_range(0, 1) == 1;
        idex_rt     = 5'($urandom_range(0, 3));
        ifid_rs     = 5'($urandom_range(0, 3));
        ifid_rt     = 5'($urandom_range(0, 3));
        pc_redirect = ($urandom_range(0, 4) == 0);
        wb_halt     = ($urandom_range(0, 59) == 0);
    endtask

    // Asserts reset away from the clock edge and checks the asynchronous effect.
    task automatic async_reset(input string tag);
        nRST = 1'b0;
        #2;
        m_halted = 1'b0; m_cycle = 0; m_stall = 0; m_flush = 0;
        check_all({tag, ".async"});
        @(posedge CLK);
        #1;
        check_all({tag, ".held"});
        nRST = 1'b1;
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        m_halted = 1'b0; m_cycle = 0; m_stall = 0; m_flush = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        for (int i = 0; i < 10; i++) step("idle");
        check_eq("idle10.cycle", {32'd0, cycle_cnt}, 64'd10);
        check_eq("idle10.stall", {32'd0, stall_cnt}, 64'd0);

        idex_DRen = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        step("loaduse");
        check_eq("loaduse.stall", {32'd0, stall_cnt}, 64'd1);
        idex_DRen = 1'b0;
        step("loaduse.after");
        idex_DRen = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        step("loaduse.r0");
        idle_inputs();

        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) step("dmiss");
        dhit = 1'b1;
        step("dmiss.hit");
        check_eq("dmiss.stall", {32'd0, stall_cnt}, 64'd4);
        idle_inputs();

        pc_redirect = 1'b1; idex_DRen = 1'b1; idex_rt = 5'd3; ifid_rt = 5'd3;
        step("redir.lu");
        check_eq("redir.flush", {32'd0, flush_cnt}, 64'd1);
        ihit = 1'b0;
        step("redir.nohit");
        check_eq("redir.nohit.flush", {32'd0, flush_cnt}, 64'd1);
        idle_inputs();

        wb_halt = 1'b1;
        step("halt.p0");
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step("halt.hold");
        end
        check_eq("halt.sticky", {63'd0, halt}, 64'd1);

        idle_inputs();
        async_reset("rst.halt");
        mem_dWEN = 1'b1; dhit = 1'b0;
        step("memwait");
        step("memwait");
        async_reset("rst.memwait");
        step("memwait.after");
        idle_inputs();

        for (int i = 0; i < 1500; i++) begin
            if (m_halted && $urandom_range(0, 7) == 0) begin
                rand_inputs();
                async_reset("rand.rst");
            end else begin
                rand_inputs();
                step("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core. It generates the enable and flush controls consumed by the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Each latch resolves its controls as: flush wins over enable; enable loads new contents; otherwise it holds.
- The unit handles cache waits, load-use hazards, control redirects and halt.
- It holds a run/wait/halt FSM and free-running performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  MEM-stage instruction is a load
mem_dWEN  in  1  MEM-stage instruction is a store
idex_DRen  in  1  EX-stage instruction is a load
idex_rt  in  5  EX-stage load destination register
ifid_rs  in  5  ID-stage source register rs
ifid_rt  in  5  ID-stage source register rt
pc_redirect  in  1  EX-stage taken branch, jump or jr
wb_halt  in  1  WB-stage instruction is halt
pc_en  out  1  PC update enable
ifid_en, ifid_flush  out  1 each  IF/ID controls
idex_en, idex_flush  out  1 each  ID/EX controls
exmem_en, exmem_flush  out  1 each  EX/MEM controls
memwb_en, memwb_flush  out  1 each  MEM/WB controls
halt  out  1  sticky core halted
cycle_cnt  out  CNT_W  non-halted cycles
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT
flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- Clock is CLK. nRST is asynchronous and active-low.
- Reset: state=RUN, halt=0, all counters=0.
- Latch controls are combinational from the current state and inputs. The state, halt and counters are registered.
- Definitions:
  - dbusy = (mem_dREN | mem_dWEN) & ~dhit
  - lu = idex_DRen & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt))
- States: RUN, MEMWAIT, HALT. Control priority in RUN and MEMWAIT, first match wins:
  - P0 wb_halt: all *_en=0; ifid_flush=idex_flush=exmem_flush=1; memwb_flush=0. Next state=HALT; halt=1 from the next cycle.
  - P1 dbusy: all *_en=0; memwb_flush=1 (bubble into WB); other flushes 0. Next state=MEMWAIT.
  - P2 ~ihit: pc_en=ifid_en=idex_en=0; exmem_flush=1 (bubble into MEM); memwb_en=1. The front end freezes and the back end drains.
  - P3 pc_redirect: all *_en=1; ifid_flush=idex_flush=1. The redirect squashes the ID instruction, so it overrides lu.
  - P4 lu: pc_en=ifid_en=0; idex_flush=1; exmem_en=memwb_en=1. This gives a one-cycle load-use bubble.
  - P5 otherwise: all *_en=1; all flushes 0.
- Next-state rules:
  - Leaving MEMWAIT: dhit=1 with ~wb_halt gives next=RUN. That same cycle's controls are evaluated by P2..P5, because dbusy=0.
  - MEMWAIT with ~dhit stays in MEMWAIT and keeps P1 controls.
  - The load/store remains in MEM throughout the wait.
- HALT:
  - All *_en=0 and all flushes=0; halt=1.
  - Inputs are ignored and the state is left only by reset.
- Counters:
  - All counters wrap modulo 2^CNT_W and are frozen in HALT.
  - cycle_cnt increments every RUN or MEMWAIT cycle, including the P0 cycle.
  - stall_cnt increments when pc_en=0 in RUN or MEMWAIT, including P0.
  - flush_cnt increments on each P3 cycle.
- Reset mid-operation: asynchronous return to RUN. Outputs reflect RUN decode immediately and counters clear.
- ihit and dhit both high is legal; priority handles it.

Test Plan:
1. Reset with ihit=1 and no hazards: all *_en=1, flushes 0, halt=0. After 10 cycles: cycle_cnt=10, stall_cnt=0.
2. Load-use: idex_DRen=1, idex_rt=8, ifid_rs=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for exactly 1 cycle; stall_cnt+1. Repeat with idex_rt=0 -> no stall.
3. Data miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> MEMWAIT for 3 cycles with all en=0 and memwb_flush=1; return to RUN on the dhit cycle; stall_cnt+=3.
4. Redirect with a load-use present: pc_redirect=1, lu=1, ihit=1 -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1. Redirect with ihit=0 -> P2 controls and flush_cnt unchanged.
5. Halt: wb_halt=1 -> P0 controls that cycle, then halt=1 with all outputs 0. Counters hold for 20 cycles while stimulus toggles.
6. Assert nRST low mid-MEMWAIT -> outputs return to RUN decode asynchronously, counters=0, halt=0.
